// File: rtl/regfile_access_ctrl_pkg.sv
// regfile_access_ctrl_pkg: shared FSM encoding and register-address constants
package regfile_access_ctrl_pkg;
   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
   localparam logic [1:0] ST_INIT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_GRANT = 2'd2;
   localparam logic [1:0] ST_ACK   = 2'd3;
endpackage

// File: rtl/regfile_access_ctrl_if.sv
// regfile_access_ctrl_if: debug/monitor request channel (req/we/addr/wdata from master, ack/rdata from slave)
interface regfile_access_ctrl_if import regfile_access_ctrl_pkg::*; #(
   parameter int REGISTER_WIDTH = 32
) ();
   logic                      req;
   logic                      we;
   logic [REG_ADDR_W-1:0]     addr;
   logic [REGISTER_WIDTH-1:0] wdata;
   logic                      ack;
   logic [REGISTER_WIDTH-1:0] rdata;
   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/regfile_access_ctrl_clear_seq.sv
// regfile_clear_seq: post-reset sweep pointer over x1..x(DEPTH-1); ports clk, resetn, ptr, last (final write this cycle), done
module regfile_clear_seq import regfile_access_ctrl_pkg::*; #(
   parameter int REGISTER_DEPTH = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   output logic [REG_ADDR_W-1:0] ptr,
   output logic                  last,
   output logic                  done
);
   assign last = !done && ptr == REG_ADDR_W'(REGISTER_DEPTH - 1);
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ptr  <= REG_ADDR_W'(1);
         done <= 1'b0;
      end else if (!done) begin
         ptr  <= ptr + REG_ADDR_W'(1);
         done <= last;
      end
   end
endmodule

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: shares the 2R/1W register file between core and debug, with post-reset clear sweep
// Ports: clk/resetn; core_* datapath side (we/waddr/wdata/raddr1/raddr2 in, rdata1/rdata2/stall/init_done out);
// dbg (regfile_access_ctrl_if.slave) debug requester; rf_* register file drive and combinational read data.
// REGFILE_CTRL_FWD_EN: when defined, same-cycle core write-to-read forwarding in RUN/ACK.
module regfile_access_ctrl import regfile_access_ctrl_pkg::*; #(
   parameter int REGISTER_WIDTH = 32,
   parameter int REGISTER_DEPTH = 32,
   parameter int STARVE_LIMIT   = 4
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      core_we,
   input  logic [REG_ADDR_W-1:0]     core_waddr,
   input  logic [REGISTER_WIDTH-1:0] core_wdata,
   input  logic [REG_ADDR_W-1:0]     core_raddr1,
   input  logic [REG_ADDR_W-1:0]     core_raddr2,
   output logic [REGISTER_WIDTH-1:0] core_rdata1,
   output logic [REGISTER_WIDTH-1:0] core_rdata2,
   output logic                      core_stall,
   output logic                      init_done,
   regfile_access_ctrl_if.slave      dbg,
   output logic                      rf_we,
   output logic [REG_ADDR_W-1:0]     rf_a1,
   output logic [REG_ADDR_W-1:0]     rf_a2,
   output logic [REG_ADDR_W-1:0]     rf_a3,
   output logic [REGISTER_WIDTH-1:0] rf_wd,
   input  logic [REGISTER_WIDTH-1:0] rf_rd1,
   input  logic [REGISTER_WIDTH-1:0] rf_rd2
);
   logic [1:0]            state;
   logic [3:0]            starve_cnt;
   logic [REG_ADDR_W-1:0] sweep_ptr;
   logic                  sweep_last;
   logic                  in_init;
   logic                  in_grant;
   logic                  grant;
   logic                  fwd1;
   logic                  fwd2;
   regfile_clear_seq #(.REGISTER_DEPTH(REGISTER_DEPTH)) u_clear (
      .clk    (clk),
      .resetn (resetn),
      .ptr    (sweep_ptr),
      .last   (sweep_last),
      .done   (init_done)
   );
   always_comb begin
      in_init     = state == ST_INIT;
      in_grant    = state == ST_GRANT;
      // debug wins on an idle core cycle, or once it has been blocked STARVE_LIMIT times
      grant       = state == ST_RUN && dbg.req && (!core_we || starve_cnt == 4'(STARVE_LIMIT));
      core_stall  = in_init || in_grant;
      rf_a1       = in_grant ? dbg.addr : core_raddr1;
      rf_a2       = core_raddr2;
      rf_a3       = in_init ? sweep_ptr : in_grant ? dbg.addr : core_waddr;
      rf_wd       = in_init ? '0 : in_grant ? dbg.wdata : core_wdata;
      rf_we       = in_init || (in_grant ? dbg.we && dbg.addr != ZERO_REG : core_we && core_waddr != ZERO_REG);
`ifdef REGFILE_CTRL_FWD_EN
      // rf_we outside INIT/GRANT already implies a nonzero core write address
      fwd1        = !core_stall && rf_we && rf_a3 == core_raddr1;
      fwd2        = !core_stall && rf_we && rf_a3 == core_raddr2;
`else
      fwd1        = 1'b0;
      fwd2        = 1'b0;
`endif
      core_rdata1 = core_raddr1 == ZERO_REG ? '0 : fwd1 ? core_wdata : rf_rd1;
      core_rdata2 = core_raddr2 == ZERO_REG ? '0 : fwd2 ? core_wdata : rf_rd2;
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_INIT;
         starve_cnt <= '0;
         dbg.ack    <= 1'b0;
         dbg.rdata  <= '0;
      end else begin
         state   <= in_init ? (sweep_last ? ST_RUN : ST_INIT) : in_grant ? ST_ACK : grant ? ST_GRANT : ST_RUN;
         dbg.ack <= in_grant;
         if (in_grant && !dbg.we)
            dbg.rdata <= dbg.addr == ZERO_REG ? '0 : rf_rd1;
         if (state == ST_RUN)
            starve_cnt <= (!dbg.req || grant) ? '0 : starve_cnt + 4'(starve_cnt != 4'hF);
      end
   end
endmodule
